axi_tagctrl_tag_req_gen: RTL and testbench

AXI_TAGCTRL_TAG_REQ_GEN -- requirements
Module: axi_tagctrl_tag_req_gen

---
 rtl/axi_tagctrl_pkg.sv | 15 +
 rtl/axi_tagctrl_tag_mask_gen.sv | 11 +
 rtl/axi_tagctrl_tag_req_gen.sv | 137 +++++++++++++
 tb/tb_axi_tagctrl_tag_req_gen.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_tagctrl_pkg.sv
// axi_tagctrl_pkg: shared request type, FSM states and burst encodings for the tag request path
package axi_tagctrl_pkg;
  localparam int TagAddrW = 64;
  localparam int TagIdW = 4;
  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstWrap = 2'b10;
  typedef enum logic [1:0] {IDLE, WALK, WRAP2, ERR} tag_gen_state_e;
  typedef struct packed {
    logic [TagAddrW-1:0] addr;
    logic [7:0]          mask;
    logic [TagIdW-1:0]   id;
    logic                write;
    logic                last;
  } tag_req_t;
endpackage

// File: rtl/axi_tagctrl_tag_mask_gen.sv
// axi_tagctrl_tag_mask_gen: sets mask bits loBit..hiBit inclusive
// Ports: loBit/hiBit in 3 (bit range), mask out 8
module axi_tagctrl_tag_mask_gen (
  input  logic [2:0] loBit,
  input  logic [2:0] hiBit,
  output logic [7:0] mask
);
  for (genvar i = 0; i < 8; i++) begin : g_bit
    assign mask[i] = (3'(i) >= loBit) && (3'(i) <= hiBit);
  end
endmodule

// File: rtl/axi_tagctrl_tag_req_gen.sv
// axi_tagctrl_tag_req_gen: turns one AXI AW/AR request into the tag-byte requests covering its capabilities
// Ports: clk_i/rst_ni (sync active-low); ax_* request in with ax_ready_o; tag_req_* valid/ready
//        stream (addr, mask, id, write, last); err_o one-cycle reject pulse; busy_o not idle.
// Macro AXI_TAGCTRL_WRAP_EN: enables WRAP bursts (two-segment walk); otherwise WRAP is rejected.
module axi_tagctrl_tag_req_gen
  import axi_tagctrl_pkg::*;
#(
  parameter int AxiAddrWidth = 64,
  parameter int AxiIdWidth = 4,
  parameter int CapSize = 128,
  parameter logic [AxiAddrWidth-1:0] DRAMMemBase = 'h8000_0000,
  parameter logic [AxiAddrWidth-1:0] DRAMMemLength = 'h4000_0000,
  parameter logic [AxiAddrWidth-1:0] TagCacheMemBase = 'hBFF0_0000
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    ax_valid_i,
  output logic                    ax_ready_o,
  input  logic [AxiAddrWidth-1:0] ax_addr_i,
  input  logic [7:0]              ax_len_i,
  input  logic [2:0]              ax_size_i,
  input  logic [1:0]              ax_burst_i,
  input  logic [AxiIdWidth-1:0]   ax_id_i,
  input  logic                    ax_write_i,
  output logic                    tag_req_valid_o,
  input  logic                    tag_req_ready_i,
  output logic [AxiAddrWidth-1:0] tag_req_addr_o,
  output logic [7:0]              tag_req_mask_o,
  output logic [AxiIdWidth-1:0]   tag_req_id_o,
  output logic                    tag_req_write_o,
  output logic                    tag_req_last_o,
  output logic                    err_o,
  output logic                    busy_o
);
  localparam int W = AxiAddrWidth + 9;
  localparam int CapShift = $clog2(CapSize / 8);
  function automatic logic [W-1:0] capOf(input logic [W-1:0] a);
    return (a - W'(DRAMMemBase)) >> CapShift;
  endfunction
  tag_gen_state_e state;
  logic [W-1:0] curCap, segEnd;
  logic [AxiIdWidth-1:0] idQ;
  logic writeQ;
  logic [W-1:0] startA, beatLen, totLen, endA, dramHi, rangeLo, rangeHi;
  logic badBurst, reject, segDone, lastReq, valid;
  logic [2:0] hiBit;
  logic [7:0] mask;
  tag_req_t req;
  assign dramHi = W'(DRAMMemBase) + W'(DRAMMemLength);
  assign startA = W'(ax_addr_i);
  assign beatLen = W'(1) << ax_size_i;
  assign totLen = (ax_burst_i == BurstFixed) ? beatLen : (W'(ax_len_i) + W'(1)) << ax_size_i;
  assign endA = (startA & ~(beatLen - W'(1))) + totLen - W'(1);
`ifdef AXI_TAGCTRL_WRAP_EN
  logic isWrap, hasSeg2;
  logic [W-1:0] wrapBase, seg2Start, seg2End;
  assign isWrap = ax_burst_i == BurstWrap;
  assign wrapBase = startA & ~(totLen - W'(1));
  // the whole wrap window must lie in DRAM, segment 1 ends at its top
  assign rangeLo = isWrap ? wrapBase : startA;
  assign rangeHi = isWrap ? wrapBase + totLen - W'(1) : endA;
  assign badBurst = ax_burst_i == 2'b11;
  assign lastReq = segDone && !hasSeg2;
`else
  assign rangeLo = startA;
  assign rangeHi = endA;
  assign badBurst = ax_burst_i == BurstWrap || ax_burst_i == 2'b11;
  assign lastReq = segDone;
`endif
  assign reject = badBurst || rangeLo < W'(DRAMMemBase) || rangeHi >= dramHi;
  assign valid = state == WALK || state == WRAP2;
  // current tag byte is the segment's last one when the cap indices share bits above [2:0]
  assign segDone = curCap[W-1:3] == segEnd[W-1:3];
  assign hiBit = segDone ? segEnd[2:0] : 3'd7;
  axi_tagctrl_tag_mask_gen u_mask (.loBit(curCap[2:0]), .hiBit(hiBit), .mask(mask));
  always_comb begin
    req = '0;
    if (valid) begin
      req.addr = TagAddrW'(W'(TagCacheMemBase) + (curCap >> 3));
      req.mask = mask;
      req.id = TagIdW'(idQ);
      req.write = writeQ;
      req.last = lastReq;
    end
  end
  assign tag_req_valid_o = valid;
  assign tag_req_addr_o = AxiAddrWidth'(req.addr);
  assign tag_req_mask_o = req.mask;
  assign tag_req_id_o = AxiIdWidth'(req.id);
  assign tag_req_write_o = req.write;
  assign tag_req_last_o = req.last;
  assign ax_ready_o = state == IDLE;
  assign err_o = state == ERR;
  assign busy_o = state != IDLE;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= IDLE;
      curCap <= '0;
      segEnd <= '0;
      idQ <= '0;
      writeQ <= 1'b0;
`ifdef AXI_TAGCTRL_WRAP_EN
      hasSeg2 <= 1'b0;
      seg2Start <= '0;
      seg2End <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (ax_valid_i) begin
          state <= reject ? ERR : WALK;
          curCap <= capOf(startA);
          segEnd <= capOf(rangeHi);
          idQ <= ax_id_i;
          writeQ <= ax_write_i;
`ifdef AXI_TAGCTRL_WRAP_EN
          hasSeg2 <= isWrap && startA != wrapBase;
          seg2Start <= capOf(wrapBase);
          seg2End <= capOf(startA - W'(1));
`endif
        end
        ERR: state <= IDLE;
        default: if (tag_req_ready_i) begin
          if (!segDone) curCap <= {curCap[W-1:3] + (W-3)'(1), 3'b000};
`ifdef AXI_TAGCTRL_WRAP_EN
          else if (hasSeg2) begin
            state <= WRAP2;
            curCap <= seg2Start;
            segEnd <= seg2End;
            hasSeg2 <= 1'b0;
          end
`endif
          else state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_axi_tagctrl_tag_req_gen.sv
// tb_axi_tagctrl_tag_req_gen: directed and randomized checks of the tag request generator against a byte-range model
module tb_axi_tagctrl_tag_req_gen;
  localparam logic [63:0] DB = 64'h8000_0000;
  localparam logic [63:0] DL = 64'h4000_0000;
  localparam logic [63:0] TB = 64'hBFF0_0000;
  typedef struct {
    logic [63:0] addr;
    logic [7:0]  mask;
    logic        last;
    logic [3:0]  id;
    logic        wr;
  } req_s;
  logic clk = 0, rst_n = 0;
  logic ax_valid = 0, ax_ready, ax_write = 0;
  logic [63:0] ax_addr = 0;
  logic [7:0] ax_len = 0;
  logic [2:0] ax_size = 0;
  logic [1:0] ax_burst = 0;
  logic [3:0] ax_id = 0;
  logic tag_req_valid, tag_req_ready = 0, tag_req_write, tag_req_last, err, busy;
  logic [63:0] tag_req_addr;
  logic [7:0] tag_req_mask;
  logic [3:0] tag_req_id;
  int vecs = 0, miscmp = 0;
  req_s obsQ[$];
  req_s expQ[$];
  bit expErr;
  int errCycles, stabViol, firstValid, doneCyc, timedOut;
  logic readyAt2;
  logic [3:0] idQ;
  logic wrQ;

  always #5 clk = ~clk;

  axi_tagctrl_tag_req_gen dut (
    .clk_i(clk), .rst_ni(rst_n),
    .ax_valid_i(ax_valid), .ax_ready_o(ax_ready), .ax_addr_i(ax_addr), .ax_len_i(ax_len),
    .ax_size_i(ax_size), .ax_burst_i(ax_burst), .ax_id_i(ax_id), .ax_write_i(ax_write),
    .tag_req_valid_o(tag_req_valid), .tag_req_ready_i(tag_req_ready), .tag_req_addr_o(tag_req_addr),
    .tag_req_mask_o(tag_req_mask), .tag_req_id_o(tag_req_id), .tag_req_write_o(tag_req_write),
    .tag_req_last_o(tag_req_last), .err_o(err), .busy_o(busy)
  );

  // one tag-byte entry per distinct tag byte touched by the segment, in address order
  task automatic add_seg(input logic [63:0] lo, input logic [63:0] hi);
    req_s r;
    bit have = 0;
    for (logic [63:0] c = (lo - DB) / 16; c <= (hi - DB) / 16; c++) begin
      if (have && r.addr != TB + c / 8) begin expQ.push_back(r); have = 0; end
      if (!have) begin r.addr = TB + c / 8; r.mask = 0; r.last = 0; r.id = 0; r.wr = 0; have = 1; end
      r.mask = r.mask | (8'd1 << (c % 8));
    end
    if (have) expQ.push_back(r);
  endtask

  task automatic model(input logic [63:0] a, input int l, input int s, input int b);
    logic [63:0] bytes, lo, hi, base;
    expQ.delete();
    bytes = (b == 0) ? (64'd1 << s) : (64'(l) + 1) << s;
    base = a - (a % bytes);
    lo = (b == 2) ? base : a;
    hi = (b == 2) ? base + bytes - 1 : a - (a % (64'd1 << s)) + bytes - 1;
    expErr = (b == 3) || lo < DB || hi >= DB + DL;
`ifndef AXI_TAGCTRL_WRAP_EN
    if (b == 2) expErr = 1;
`endif
    if (expErr) return;
    add_seg(a, hi);
    if (b == 2 && a != base) add_seg(base, a - 1);
    expQ[expQ.size() - 1].last = 1;
  endtask

  // drives one AX handshake then services the tag stream, recording what it sees; call at a negedge
  task automatic run_burst(input logic [63:0] a, input int l, input int s, input int b, input int readyPct, input int holdLow);
    int n = 0;
    bit pv = 0, pr = 0, done = 0;
    req_s p, r;
    obsQ.delete();
    errCycles = 0; stabViol = 0; firstValid = -1; doneCyc = -1; timedOut = 0; readyAt2 = 0;
    idQ = 4'($urandom); wrQ = 1'($urandom);
    ax_addr = a; ax_len = 8'(l); ax_size = 3'(s); ax_burst = 2'(b); ax_id = idQ; ax_write = wrQ;
    ax_valid = 1; tag_req_ready = 0;
    while (!ax_ready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) timedOut = 1;
    @(negedge clk);
    ax_valid = 0; ax_addr = {$urandom, $urandom}; ax_id = 4'($urandom); ax_write = ~wrQ;
    for (int c = 1; c <= 300 && !done; c++) begin
      if (c == 2) readyAt2 = ax_ready;
      if (err) errCycles++;
      if (tag_req_valid && firstValid < 0) firstValid = c;
      if (pv && !pr && (!tag_req_valid || tag_req_addr !== p.addr || tag_req_mask !== p.mask ||
          tag_req_last !== p.last || tag_req_id !== p.id || tag_req_write !== p.wr)) stabViol++;
      if (!busy) begin done = 1; doneCyc = c; tag_req_ready = 0; end
      else begin
        tag_req_ready = (c <= holdLow) ? 1'b0 : ($urandom_range(1, 100) <= readyPct);
        r.addr = tag_req_addr; r.mask = tag_req_mask; r.last = tag_req_last; r.id = tag_req_id; r.wr = tag_req_write;
        if (tag_req_valid && tag_req_ready) obsQ.push_back(r);
        pv = tag_req_valid; pr = tag_req_ready; p = r;
        @(negedge clk);
      end
    end
    if (!done) timedOut = 1;
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (3) @(negedge clk);
    vecs++;
    if ({tag_req_valid, err, busy, ax_ready} !== 4'b0001) begin
      miscmp++; $display("FAIL reset_ctrl: valid/err/busy/ready got %b want 0001", {tag_req_valid, err, busy, ax_ready});
    end
    vecs++;
    if ({tag_req_addr, tag_req_mask, tag_req_id, tag_req_write, tag_req_last} !== '0) begin
      miscmp++; $display("FAIL reset_data: addr %0h mask %0h id %0h got nonzero, want 0", tag_req_addr, tag_req_mask, tag_req_id);
    end
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_incr_single;
    run_burst(64'h8000_0000, 3, 3, 1, 100, 0);
    vecs++;
    if (obsQ.size() != 1 || timedOut != 0) begin
      miscmp++; $display("FAIL incr_single_count: got %0d reqs (timeout %0d) want 1", obsQ.size(), timedOut);
    end else begin
      vecs++;
      if (obsQ[0].addr !== 64'hBFF0_0000 || obsQ[0].mask !== 8'h03 || obsQ[0].last !== 1'b1 || obsQ[0].id !== idQ || obsQ[0].wr !== wrQ) begin
        miscmp++; $display("FAIL incr_single_req: got addr %0h mask %0h last %0b want BFF00000 03 1", obsQ[0].addr, obsQ[0].mask, obsQ[0].last);
      end
    end
    vecs++;
    if (firstValid != 1) begin miscmp++; $display("FAIL first_valid_latency: got cycle %0d want 1", firstValid); end
  endtask

  task automatic test_incr_cross;
    run_burst(64'h8000_0070, 7, 3, 1, 100, 0);
    vecs++;
    if (obsQ.size() != 2) begin
      miscmp++; $display("FAIL incr_cross_count: got %0d want 2", obsQ.size());
    end else begin
      vecs++;
      if (obsQ[0].addr !== 64'hBFF0_0000 || obsQ[0].mask !== 8'h80 || obsQ[0].last !== 1'b0) begin
        miscmp++; $display("FAIL incr_cross_req0: got %0h %0h %0b want BFF00000 80 0", obsQ[0].addr, obsQ[0].mask, obsQ[0].last);
      end
      vecs++;
      if (obsQ[1].addr !== 64'hBFF0_0001 || obsQ[1].mask !== 8'h07 || obsQ[1].last !== 1'b1) begin
        miscmp++; $display("FAIL incr_cross_req1: got %0h %0h %0b want BFF00001 07 1", obsQ[1].addr, obsQ[1].mask, obsQ[1].last);
      end
    end
    vecs++;
    if (doneCyc != 3) begin miscmp++; $display("FAIL throughput: idle at cycle %0d want 3", doneCyc); end
  endtask

  task automatic test_wrap;
    run_burst(64'h8000_0030, 3, 4, 2, 100, 0);
`ifdef AXI_TAGCTRL_WRAP_EN
    vecs++;
    if (obsQ.size() != 2 || errCycles != 0) begin
      miscmp++; $display("FAIL wrap_count: got %0d reqs %0d err want 2 0", obsQ.size(), errCycles);
    end else begin
      vecs++;
      if (obsQ[0].addr !== 64'hBFF0_0000 || obsQ[0].mask !== 8'h08 || obsQ[0].last !== 1'b0 ||
          obsQ[1].addr !== 64'hBFF0_0000 || obsQ[1].mask !== 8'h07 || obsQ[1].last !== 1'b1) begin
        miscmp++; $display("FAIL wrap_reqs: got %0h/%0b %0h/%0b want 08/0 07/1", obsQ[0].mask, obsQ[0].last, obsQ[1].mask, obsQ[1].last);
      end
    end
`else
    vecs++;
    if (obsQ.size() != 0 || errCycles != 1 || firstValid != -1) begin
      miscmp++; $display("FAIL wrap_disabled: got %0d reqs %0d err cycles want 0 1", obsQ.size(), errCycles);
    end
`endif
  endtask

  task automatic test_err;
    run_burst(64'h7FFF_FFF0, 0, 2, 1, 100, 0);
    vecs++;
    if (errCycles != 1) begin miscmp++; $display("FAIL err_pulse: got %0d cycles want 1", errCycles); end
    vecs++;
    if (firstValid != -1 || obsQ.size() != 0) begin miscmp++; $display("FAIL err_no_req: got valid at cycle %0d want none", firstValid); end
    vecs++;
    if (readyAt2 !== 1'b1) begin miscmp++; $display("FAIL err_ready: got %b at cycle 2 want 1", readyAt2); end
    run_burst(64'h8000_0000, 0, 2, 3, 100, 0);
    vecs++;
    if (errCycles != 1 || obsQ.size() != 0) begin miscmp++; $display("FAIL err_burst3: got %0d err %0d reqs want 1 0", errCycles, obsQ.size()); end
    run_burst(DB + DL - 64'h10, 1, 4, 1, 100, 0);
    vecs++;
    if (errCycles != 1 || obsQ.size() != 0) begin miscmp++; $display("FAIL err_top: got %0d err %0d reqs want 1 0", errCycles, obsQ.size()); end
  endtask

  task automatic test_backpressure;
    run_burst(64'h8000_0070, 7, 3, 1, 100, 5);
    vecs++;
    if (stabViol != 0 || timedOut != 0) begin miscmp++; $display("FAIL stall_stable: got %0d violations want 0", stabViol); end
    vecs++;
    if (obsQ.size() != 2 || obsQ[0].mask !== 8'h80 || obsQ[1].mask !== 8'h07 || obsQ[1].addr !== 64'hBFF0_0001) begin
      miscmp++; $display("FAIL stall_order: got %0d reqs want 80 then 07", obsQ.size());
    end
    vecs++;
    if (doneCyc != 8) begin miscmp++; $display("FAIL stall_done: idle at cycle %0d want 8", doneCyc); end
  endtask

  task automatic test_reset_mid;
    int seen = 0;
    ax_addr = DB; ax_len = 15; ax_size = 6; ax_burst = 1; ax_valid = 1; tag_req_ready = 0;
    @(negedge clk);
    ax_valid = 0;
    vecs++;
    if (tag_req_valid !== 1'b1) begin miscmp++; $display("FAIL mid_walk: got valid %b want 1", tag_req_valid); end
    tag_req_ready = 1;
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    vecs++;
    if (tag_req_valid !== 1'b0 || ax_ready !== 1'b1 || busy !== 1'b0) begin
      miscmp++; $display("FAIL mid_reset: got valid %b ready %b busy %b want 0 1 0", tag_req_valid, ax_ready, busy);
    end
    rst_n = 1;
    repeat (12) begin @(negedge clk); if (tag_req_valid) seen++; end
    vecs++;
    if (seen != 0) begin miscmp++; $display("FAIL mid_residual: got %0d valid cycles want 0", seen); end
    tag_req_ready = 0;
  endtask

  task automatic test_random;
    logic [63:0] a;
    int l, s, b;
    for (int k = 0; k < 80; k++) begin
      case ($urandom_range(0, 9))
        0: a = DB - 64'($urandom_range(1, 64));
        1: a = DB + DL - 64'($urandom_range(1, 512));
        default: a = DB + 64'($urandom_range(0, 'h2000));
      endcase
      b = $urandom_range(0, 3);
      s = $urandom_range(0, 6);
      l = (b == 2) ? (2 << $urandom_range(0, 3)) - 1 : $urandom_range(0, 15);
      model(a, l, s, b);
      run_burst(a, l, s, b, 70, 0);
      vecs++;
      if (errCycles != (expErr ? 1 : 0)) begin
        miscmp++; $display("FAIL rnd_err a=%0h l=%0d s=%0d b=%0d: got %0d want %0d", a, l, s, b, errCycles, expErr);
      end
      vecs++;
      if (timedOut != 0 || stabViol != 0) begin
        miscmp++; $display("FAIL rnd_proto a=%0h: got timeout %0d stab %0d want 0 0", a, timedOut, stabViol);
      end
      vecs++;
      if (obsQ.size() != expQ.size()) begin
        miscmp++; $display("FAIL rnd_count a=%0h l=%0d s=%0d b=%0d: got %0d want %0d", a, l, s, b, obsQ.size(), expQ.size());
      end else begin
        for (int i = 0; i < expQ.size(); i++) begin
          vecs++;
          if (obsQ[i].addr !== expQ[i].addr || obsQ[i].mask !== expQ[i].mask || obsQ[i].last !== expQ[i].last ||
              obsQ[i].id !== idQ || obsQ[i].wr !== wrQ) begin
            miscmp++;
            $display("FAIL rnd_req%0d a=%0h: got %0h/%0h/%0b/%0h want %0h/%0h/%0b/%0h", i, a, obsQ[i].addr, obsQ[i].mask,
                     obsQ[i].last, obsQ[i].id, expQ[i].addr, expQ[i].mask, expQ[i].last, idQ);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_incr_single;
    test_incr_cross;
    test_wrap;
    test_err;
    test_backpressure;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end
endmodule
